// File: rtl/dct_mac_sequencer.sv
// Sequences one 8-tap DCT multiply-accumulate unit over 8 coefficients,
// waits out the MAC pipeline and hands each result downstream.
module dct_mac_sequencer #(
  parameter int MAC_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       blk_valid,
  output logic       blk_ready,
  output logic       mac_ena,
  output logic       mac_clr,
  output logic [2:0] coef_row,
  output logic [2:0] coef_col,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [2:0] res_idx,
  output logic       res_last,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [2:0] LAT3 = 3'(MAC_LAT);

  state_t     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [2:0] tap_q, tap_d;
  logic [2:0] drn_q, drn_d;
  logic       done_q, done_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tap_d   = tap_q;
    drn_d   = drn_q;
    done_d  = done_q;
    if (ena) begin
      done_d = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (blk_valid) begin
            row_d   = 3'd0;
            tap_d   = 3'd0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (tap_q == 3'd7) begin
            drn_d   = LAT3;
            state_d = DRAIN;
          end else begin
            tap_d = tap_q + 3'd1;
          end
        end
        DRAIN: begin
          drn_d = drn_q - 3'd1;
          if (drn_q == 3'd1) state_d = HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            if (row_q == 3'd7) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              row_d   = row_q + 3'd1;
              tap_d   = 3'd0;
              state_d = ACCUM;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= 3'd0;
      tap_q   <= 3'd0;
      drn_q   <= 3'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      tap_q   <= tap_d;
      drn_q   <= drn_d;
      done_q  <= done_d;
    end
  end

  // MAC strobes are the only outputs that see ena directly
  assign mac_ena   = ena && (state_q == ACCUM);
  assign mac_clr   = mac_ena && (tap_q == 3'd0);
  assign blk_ready = !rst && (state_q == IDLE);
  assign coef_row  = row_q;
  assign coef_col  = tap_q;
  assign res_valid = (state_q == HOLD);
  assign res_idx   = row_q;
  assign res_last  = (state_q == HOLD) && (row_q == 3'd7);
  assign done      = done_q;

endmodule

// File: tb/tb_dct_mac_sequencer.sv
// Bench: cycle timeline model on a MAC_LAT=2 instance, plus a randomized
// scoreboard with a MAC model and golden DCT sums on a MAC_LAT=5 instance.
module tb_dct_mac_sequencer;

  localparam int LA = 2;
  localparam int LB = 5;
  localparam int NB = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(string nm, logic signed [31:0] act,
                     logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic       a_rst, a_ena, a_bv, a_br, a_me, a_mc, a_rv, a_rdy;
  logic       a_last, a_done;
  logic [2:0] a_row, a_col, a_idx;

  dct_mac_sequencer #(.MAC_LAT(LA)) u_a (
    .clk(clk), .rst(a_rst), .ena(a_ena),
    .blk_valid(a_bv), .blk_ready(a_br),
    .mac_ena(a_me), .mac_clr(a_mc),
    .coef_row(a_row), .coef_col(a_col),
    .res_valid(a_rv), .res_ready(a_rdy),
    .res_idx(a_idx), .res_last(a_last), .done(a_done)
  );

  logic       b_rst, b_ena, b_bv, b_br, b_me, b_mc, b_rv, b_rdy;
  logic       b_last, b_done;
  logic [2:0] b_row, b_col, b_idx;

  dct_mac_sequencer #(.MAC_LAT(LB)) u_b (
    .clk(clk), .rst(b_rst), .ena(b_ena),
    .blk_valid(b_bv), .blk_ready(b_br),
    .mac_ena(b_me), .mac_clr(b_mc),
    .coef_row(b_row), .coef_col(b_col),
    .res_valid(b_rv), .res_ready(b_rdy),
    .res_idx(b_idx), .res_last(b_last), .done(b_done)
  );

  // ---------------- timeline model (instance A) ----------------
  typedef struct {
    bit ena, rdy, bv, rst, chk, cc, ci;
    bit me, mc, rv, last, done, br;
    int row, col, idx;
  } cyc_t;

  cyc_t tl[$];

  function automatic cyc_t idle_rec(bit bv);
    cyc_t r = '{default: 0};
    r.ena = 1; r.rdy = 1; r.bv = bv; r.chk = 1; r.br = 1;
    return r;
  endfunction

  // sr/sn: stall row and length; er/et/en: ena-low row, tap, length
  task automatic add_block(int sr, int sn, int er, int et, int en,
                           bit bvd, bit bvl);
    cyc_t r;
    int   ns;
    for (int k = 0; k < 8; k++) begin
      for (int t = 0; t < 8; t++) begin
        r = '{default: 0};
        r.chk = 1; r.rdy = 1; r.bv = bvd; r.cc = 1;
        r.row = k; r.col = t;
        if (k == er && t == et) begin
          r.ena = 0;
          repeat (en) tl.push_back(r);
        end
        r.ena = 1; r.me = 1; r.mc = (t == 0);
        tl.push_back(r);
      end
      r = '{default: 0};
      r.chk = 1; r.ena = 1; r.rdy = 1; r.bv = bvd;
      repeat (LA) tl.push_back(r);
      ns = (k == sr) ? sn : 0;
      for (int s = 0; s <= ns; s++) begin
        r.rv = 1; r.idx = k; r.last = (k == 7);
        r.rdy = (s == ns);
        tl.push_back(r);
      end
    end
    r = '{default: 0};
    r.chk = 1; r.ena = 1; r.rdy = 1; r.bv = bvl;
    r.done = 1; r.br = 1;
    tl.push_back(r);
  endtask

  // ---------------- scoreboard + MAC model (instance B) ----------------
  typedef struct {
    int idx, last, val, at;
  } sb_t;

  sb_t sb[$];
  int  ctab[8][8];
  int  blk_x[8];
  int  acc = 0;
  bit  pv[LB-1];
  bit  pc[LB-1];
  int  pp[LB-1];
  int  nacc = 0;
  int  ndone = 0;

  function automatic int cosv(int m);
    int c16[9] = '{64, 63, 59, 53, 45, 36, 24, 12, 0};
    int mm = m % 32;
    if (mm <= 8)  return c16[mm];
    if (mm <= 16) return -c16[16-mm];
    if (mm <= 24) return -c16[mm-16];
    return c16[32-mm];
  endfunction

  always @(negedge clk) begin
    sb_t e;
    int  sum;
    if (b_rst) begin
      acc = 0;
      for (int i = 0; i < LB-1; i++) begin
        pv[i] = 0; pc[i] = 0; pp[i] = 0;
      end
    end else if (b_ena) begin
      if (b_rv && b_rdy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: got result idx %0d expected none", b_idx);
        end else begin
          e = sb.pop_front();
          chk("res_idx", b_idx, e.idx);
          chk("res_last", b_last, e.last);
          chk($sformatf("result[%0d]", e.idx), acc, e.val);
          if (e.at >= 0) chk($sformatf("res_at[%0d]", e.idx), ncyc, e.at);
        end
      end
      if (b_done) ndone++;
      if (b_bv && b_br) begin
        nacc++;
        for (int n = 0; n < 8; n++) blk_x[n] = $urandom_range(0, 255) - 128;
        for (int k = 0; k < 8; k++) begin
          sum = 0;
          for (int n = 0; n < 8; n++) sum += ctab[k][n] * blk_x[n];
          e.idx = k; e.last = (k == 7); e.val = sum;
          e.at = (nacc == 1) ? ncyc + (9 + LB) * (k + 1) : -1;
          sb.push_back(e);
        end
      end
      if (pv[LB-2]) acc = pc[LB-2] ? pp[LB-2] : acc + pp[LB-2];
      for (int i = LB-2; i > 0; i--) begin
        pv[i] = pv[i-1]; pc[i] = pc[i-1]; pp[i] = pp[i-1];
      end
      pv[0] = b_me;
      pc[0] = b_mc;
      pp[0] = b_me ? ctab[b_row][b_col] * blk_x[b_col] : 0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    cyc_t r;
    int   base;
    bit   fin;

    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++)
        ctab[k][n] = (k == 0) ? 45 : cosv((2*n + 1) * k);

    a_rst = 1; a_ena = 1; a_bv = 1; a_rdy = 1;
    b_rst = 1; b_ena = 1; b_bv = 0; b_rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_blk_ready", a_br, 0);
    chk("rst_mac_ena", a_me, 0);
    chk("rst_mac_clr", a_mc, 0);
    chk("rst_res_valid", a_rv, 0);
    chk("rst_res_last", a_last, 0);
    chk("rst_done", a_done, 0);
    chk("rst_coef_row", a_row, 0);
    chk("rst_coef_col", a_col, 0);
    chk("rst_res_idx", a_idx, 0);
    a_rst = 0; a_bv = 0;
    #1;
    chk("post_rst_blk_ready", a_br, 1);

    tl.push_back(idle_rec(1));
    add_block(-1, 0, -1, 0, 0, 0, 0);
    tl.push_back(idle_rec(1));
    add_block(3, 5, -1, 0, 0, 0, 0);
    tl.push_back(idle_rec(1));
    add_block(-1, 0, 2, 4, 3, 0, 0);
    tl.push_back(idle_rec(1));
    add_block(-1, 0, -1, 0, 0, 1, 1);
    add_block(-1, 0, -1, 0, 0, 0, 0);
    base = tl.size();
    tl.push_back(idle_rec(1));
    add_block(-1, 0, -1, 0, 0, 0, 0);
    while (tl.size() > base + 31) void'(tl.pop_back());
    tl[base+30].rst = 1;
    tl[base+30].chk = 0;
    r = idle_rec(0);
    r.cc = 1; r.ci = 1;
    tl.push_back(r);
    repeat (12) tl.push_back(idle_rec(0));

    foreach (tl[i]) begin
      @(posedge clk);
      #1;
      a_ena = tl[i].ena; a_rdy = tl[i].rdy;
      a_bv = tl[i].bv; a_rst = tl[i].rst;
      #1;
      if (tl[i].chk) begin
        chk($sformatf("mac_ena@%0d", i), a_me, tl[i].me);
        chk($sformatf("mac_clr@%0d", i), a_mc, tl[i].mc);
        chk($sformatf("res_valid@%0d", i), a_rv, tl[i].rv);
        chk($sformatf("res_last@%0d", i), a_last, tl[i].last);
        chk($sformatf("done@%0d", i), a_done, tl[i].done);
        chk($sformatf("blk_ready@%0d", i), a_br, tl[i].br);
        if (tl[i].cc) begin
          chk($sformatf("coef_row@%0d", i), a_row, tl[i].row);
          chk($sformatf("coef_col@%0d", i), a_col, tl[i].col);
        end
        if (tl[i].rv || tl[i].ci)
          chk($sformatf("res_idx@%0d", i), a_idx, tl[i].idx);
      end
    end

    @(posedge clk);
    #1;
    b_rst = 0;
    fin = 0;
    for (int c = 0; c < 6000 && !fin; c++) begin
      @(posedge clk);
      #1;
      if (ndone == 0) begin
        b_ena = 1; b_rdy = 1; b_bv = (nacc == 0);
      end else begin
        b_ena = ($urandom_range(0, 7) != 0);
        b_rdy = ($urandom_range(0, 3) != 0);
        b_bv  = (nacc < NB) && ($urandom_range(0, 1) == 1);
      end
      fin = (nacc == NB) && (ndone == NB) && (sb.size() == 0);
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout: got acc=%0d done=%0d pending=%0d expected %0d blocks",
               nacc, ndone, sb.size(), NB);
    end
    chk("done_count", ndone, NB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
